// File: rtl/prog_sequencer_if.sv
// prog_sequencer_if: bundles the sequencer's decoder/datapath/handshake signals.
//
// Handshake semantics: Start is a level request from the host; the sequencer
// raises Ack in HALT and holds it until Start is seen low, after which it
// returns to IDLE and a fresh low-to-high Start is needed to run again.
//
// Signals:
//   Start, Done, Branch, Lookup, BranchCond, Target, MemRead : into sequencer
//   PC, WriteEn, Busy, Ack, CycleCount, dbg_state            : out of sequencer
// Modports: master = decoder/host side, slave = sequencer side.
interface prog_sequencer_if #(
  parameter int PCW  = 10,
  parameter int CNTW = 16
);
  logic            Start;
  logic            Done;
  logic            Branch;
  logic            Lookup;
  logic            BranchCond;
  logic [PCW-1:0]  Target;
  logic            MemRead;
  logic [PCW-1:0]  PC;
  logic            WriteEn;
  logic            Busy;
  logic            Ack;
  logic [CNTW-1:0] CycleCount;
  logic [1:0]      dbg_state;

  modport master (
    output Start, Done, Branch, Lookup, BranchCond, Target, MemRead,
    input  PC, WriteEn, Busy, Ack, CycleCount, dbg_state
  );

  modport slave (
    input  Start, Done, Branch, Lookup, BranchCond, Target, MemRead,
    output PC, WriteEn, Busy, Ack, CycleCount, dbg_state
  );
endinterface

// File: rtl/prog_sequencer.sv
// prog_sequencer: program counter and run/halt FSM for the accumulator processor.
//
// Ports:
//   Clk   - clock, all state changes on rising edge
//   Reset - synchronous active-high reset
//   bus   - prog_sequencer_if.slave: decoder strobes, lookup Target, Start/Ack
//           handshake in; PC, WriteEn, Busy, Ack, CycleCount and dbg_state
//           (current FSM state) out.
module prog_sequencer #(
  parameter int PCW        = 10,
  parameter int START_ADDR = 0,
  parameter int CNTW       = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  prog_sequencer_if.slave    bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  localparam logic [PCW-1:0]  START_PC = PCW'(START_ADDR);
  localparam logic [CNTW-1:0] CNT_MAX  = {CNTW{1'b1}};

  logic [1:0]      r_state;
  logic [PCW-1:0]  r_pc;
  logic [CNTW-1:0] r_cnt;

  logic [1:0]      w_state_nxt;
  logic [PCW-1:0]  w_pc_nxt;
  logic [PCW-1:0]  w_pc_inc;
  logic            w_take_branch;
  logic            w_write_en;

  // Natural PCW-bit overflow gives the required wrap to zero.
  assign w_pc_inc      = r_pc + 1'b1;
  assign w_take_branch = bus.Branch & bus.Lookup & bus.BranchCond;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    unique case (r_state)
      S_IDLE: begin
        w_pc_nxt = START_PC;
        if (bus.Start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        // Priority: halt, then load address phase, then taken branch, then step.
        if (bus.Done) begin
          w_state_nxt = S_HALT;
        end else if (bus.MemRead) begin
          w_state_nxt = S_WAIT;
        end else if (w_take_branch) begin
          w_pc_nxt = bus.Target;
        end else begin
          w_pc_nxt = w_pc_inc;
        end
      end
      S_WAIT: begin
        // Load data phase: decoder strobes are not looked at here.
        w_pc_nxt    = w_pc_inc;
        w_state_nxt = S_RUN;
      end
      S_HALT: begin
        if (!bus.Start) begin
          w_state_nxt = S_IDLE;
          w_pc_nxt    = START_PC;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_pc_nxt    = START_PC;
      end
    endcase
  end

  // In RUN, the commit strobe is suppressed on halt and on a load's address
  // phase, so it also depends on the current Done/MemRead strobes.
  always_comb begin
    w_write_en = 1'b0;
    if (r_state == S_WAIT) w_write_en = 1'b1;
    else if (r_state == S_RUN) w_write_en = !bus.Done && !bus.MemRead;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_pc    <= START_PC;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (r_state == S_IDLE && bus.Start) begin
        r_cnt <= '0;
      end else if ((r_state == S_RUN || r_state == S_WAIT) && r_cnt != CNT_MAX) begin
        // Every edge that ends a RUN or WAIT cycle counts, saturating.
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.PC         = r_pc;
  assign bus.WriteEn    = w_write_en;
  assign bus.Busy       = (r_state == S_RUN) || (r_state == S_WAIT);
  assign bus.Ack        = (r_state == S_HALT);
  assign bus.CycleCount = r_cnt;
  assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_prog_sequencer.sv
// tb_prog_sequencer: directed bench for prog_sequencer (default widths) plus a
// second instance with CNTW=4 for counter saturation.
module tb_prog_sequencer;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  prog_sequencer_if #(.PCW(10), .CNTW(16)) m_if ();
  prog_sequencer_if #(.PCW(10), .CNTW(4))  s_if ();

  prog_sequencer #(.PCW(10), .START_ADDR(0), .CNTW(16)) u_dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (m_if.slave)
  );

  prog_sequencer #(.PCW(10), .START_ADDR(0), .CNTW(4)) u_small (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (s_if.slave)
  );

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_HALT = 2'd3;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- driver tasks ----------------
  // Advance to just after the next rising edge; inputs are then changed and
  // outputs sampled well away from the edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic dec(input logic done, input logic br, input logic lk,
                     input logic bc, input logic [9:0] tgt, input logic mr);
    m_if.Done       = done;
    m_if.Branch     = br;
    m_if.Lookup     = lk;
    m_if.BranchCond = bc;
    m_if.Target     = tgt;
    m_if.MemRead    = mr;
    #1;
  endtask

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_core(input string tag, input logic [1:0] st, input logic [9:0] pc,
                            input logic we);
    check({tag, "_state"}, 32'(m_if.dbg_state), 32'(st));
    check({tag, "_pc"},    32'(m_if.PC),        32'(pc));
    check({tag, "_we"},    32'(m_if.WriteEn),   32'(we));
  endtask

  initial begin
    Reset = 1'b1;
    m_if.Start = 1'b0;
    s_if.Start = 1'b0;
    s_if.Done = 1'b0; s_if.Branch = 1'b0; s_if.Lookup = 1'b0;
    s_if.BranchCond = 1'b0; s_if.Target = '0; s_if.MemRead = 1'b0;
    dec(0, 0, 0, 0, 10'h000, 0);
    tick(); tick();
    Reset = 1'b0;

    // ---- reset state ----
    check_core("rst", ST_IDLE, 10'h000, 1'b0);
    check("rst_busy", 32'(m_if.Busy), 32'd0);
    check("rst_ack",  32'(m_if.Ack),  32'd0);
    check("rst_cnt",  32'(m_if.CycleCount), 32'd0);

    // ---- straight-line program: 0,1,2, Done at 3 ----
    m_if.Start = 1'b1;
    tick();
    check_core("p1_a0", ST_RUN, 10'h000, 1'b1);
    check("p1_busy", 32'(m_if.Busy), 32'd1);
    tick(); check_core("p1_a1", ST_RUN, 10'h001, 1'b1);
    tick(); check_core("p1_a2", ST_RUN, 10'h002, 1'b1);
    tick(); dec(1, 0, 0, 0, 10'h000, 0);
    check_core("p1_a3_done", ST_RUN, 10'h003, 1'b0);
    tick(); dec(0, 0, 0, 0, 10'h000, 0);
    check_core("p1_halt", ST_HALT, 10'h003, 1'b0);
    check("p1_ack",  32'(m_if.Ack),  32'd1);
    check("p1_busy_h", 32'(m_if.Busy), 32'd0);
    check("p1_cnt",  32'(m_if.CycleCount), 32'd4);
    // Start still high: no restart.
    tick(); tick();
    check_core("p1_hold", ST_HALT, 10'h003, 1'b0);
    check("p1_ack_hold", 32'(m_if.Ack), 32'd1);
    m_if.Start = 1'b0;
    tick();
    check_core("p1_idle", ST_IDLE, 10'h000, 1'b0);
    check("p1_ack_drop", 32'(m_if.Ack), 32'd0);
    check("p1_cnt_keep", 32'(m_if.CycleCount), 32'd4);

    // ---- load, taken branch, halt priority ----
    m_if.Start = 1'b1;
    tick();
    m_if.Start = 1'b0;  // ignored while running
    check_core("p2_a0", ST_RUN, 10'h000, 1'b1);
    check("p2_cnt_clr", 32'(m_if.CycleCount), 32'd0);
    tick(); dec(0, 0, 0, 0, 10'h000, 1);
    check_core("p2_ld_addr", ST_RUN, 10'h001, 1'b0);
    tick(); dec(1, 1, 1, 1, 10'h155, 1);  // decoder inputs ignored in WAIT
    check_core("p2_ld_wait", ST_WAIT, 10'h001, 1'b1);
    check("p2_busy_w", 32'(m_if.Busy), 32'd1);
    tick(); dec(0, 1, 1, 1, 10'h1F0, 0);
    check_core("p2_br", ST_RUN, 10'h002, 1'b1);
    tick(); dec(1, 1, 1, 1, 10'h055, 0);
    check_core("p2_tgt", ST_RUN, 10'h1F0, 1'b0);
    tick(); dec(0, 0, 0, 0, 10'h000, 0);
    check_core("p2_halt", ST_HALT, 10'h1F0, 1'b0);
    check("p2_cnt", 32'(m_if.CycleCount), 32'd5);
    tick();
    check_core("p2_idle", ST_IDLE, 10'h000, 1'b0);

    // ---- not-taken branch, load beats branch, wrap ----
    m_if.Start = 1'b1;
    tick(); check_core("p3_a0", ST_RUN, 10'h000, 1'b1);
    tick(); check_core("p3_a1", ST_RUN, 10'h001, 1'b1);
    tick(); dec(0, 1, 1, 0, 10'h1F0, 0);
    check_core("p3_nt", ST_RUN, 10'h002, 1'b1);
    tick(); dec(0, 1, 1, 1, 10'h1F0, 1);
    check_core("p3_ldbr", ST_RUN, 10'h003, 1'b0);
    tick(); dec(0, 0, 0, 0, 10'h000, 0);
    check_core("p3_wait", ST_WAIT, 10'h003, 1'b1);
    tick(); dec(0, 1, 1, 1, 10'h3FF, 0);
    check_core("p3_a4", ST_RUN, 10'h004, 1'b1);
    tick(); dec(0, 0, 0, 0, 10'h000, 0);
    check_core("p3_top", ST_RUN, 10'h3FF, 1'b1);
    tick(); dec(0, 0, 0, 0, 10'h000, 1);
    check_core("p3_wrap", ST_RUN, 10'h000, 1'b0);
    tick(); dec(0, 0, 0, 0, 10'h000, 0);
    check_core("p3_wait2", ST_WAIT, 10'h000, 1'b1);
    check("p3_cnt", 32'(m_if.CycleCount), 32'd8);
    // Reset in WAIT: pending load never commits, back to IDLE.
    Reset = 1'b1;
    m_if.Start = 1'b0;
    tick();
    Reset = 1'b0;
    check_core("p3_rst", ST_IDLE, 10'h000, 1'b0);
    check("p3_rst_busy", 32'(m_if.Busy), 32'd0);
    check("p3_rst_cnt", 32'(m_if.CycleCount), 32'd0);

    // ---- CNTW=4 saturation on a 20-cycle program ----
    s_if.Start = 1'b1;
    tick();  // now RUN, count 0
    for (int i = 0; i < 14; i++) tick();
    check("sat_14", 32'(s_if.CycleCount), 32'd14);
    for (int i = 0; i < 5; i++) tick();
    check("sat_15", 32'(s_if.CycleCount), 32'd15);
    check("sat_busy", 32'(s_if.Busy), 32'd1);
    s_if.Done = 1'b1;
    tick();
    s_if.Done = 1'b0;
    check("sat_ack", 32'(s_if.Ack), 32'd1);
    check("sat_halt_cnt", 32'(s_if.CycleCount), 32'd15);
    check("sat_pc", 32'(s_if.PC), 32'd19);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
